// File: rtl/aes_pkg.sv
// Shared AES definitions: S-box table, key-length encodings, Nk/Nr lookup, xtime.
package aes_pkg;

  localparam logic [1:0] KEYLEN_128 = 2'd0;
  localparam logic [1:0] KEYLEN_192 = 2'd1;
  localparam logic [1:0] KEYLEN_256 = 2'd2;
  localparam logic [1:0] KEYLEN_ILL = 2'd3;

  typedef enum logic {ST_IDLE = 1'b0, ST_EXPAND = 1'b1} ks_state_t;

  // S-box entry 0 sits in the top byte
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox_lookup(input logic [7:0] x);
    return SBOX_TBL[{~x, 3'b111} -: 8];
  endfunction

  function automatic logic [3:0] nk_of(input logic [1:0] kl);
    case (kl)
      KEYLEN_128: return 4'd4;
      KEYLEN_192: return 4'd6;
      KEYLEN_256: return 4'd8;
      default:    return 4'd0;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input logic [1:0] kl);
    case (kl)
      KEYLEN_128: return 4'd10;
      KEYLEN_192: return 4'd12;
      KEYLEN_256: return 4'd14;
      KEYLEN_ILL: return 4'd0;
      default:    return 4'd0;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational 8-bit AES S-box lookup.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] i_a,
  output logic [7:0] o_y_c
);

  assign o_y_c = sbox_lookup(i_a);

endmodule

// File: rtl/aes_key_schedule_seq.sv
// Iterative AES-128/192/256 key expansion, one word per clock, with a registered
// 128-bit round-key read port.
module aes_key_schedule_seq
  import aes_pkg::*;
#(
  parameter int unsigned NK_MAX = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   key_len,
  input  logic [255:0] key,
  output logic         busy,
  output logic         done,
  output logic         keys_valid,
  output logic         err,
  input  logic [3:0]   rk_idx,
  output logic [127:0] rk_out
);

  localparam int unsigned NW = 4 * (NK_MAX + 7);
  localparam int unsigned IW = 6;

  logic [31:0]   r_w [NW];
  ks_state_t     r_state;
  logic [3:0]    r_nk;
  logic [3:0]    r_nr;
  logic [IW-1:0] r_i;
  logic [3:0]    r_p;
  logic [7:0]    r_rcon;
  logic          r_busy;
  logic          r_done;
  logic          r_keys_valid;
  logic          r_err;
  logic [127:0]  r_rk_out;

  logic [3:0]    w_nk_req;
  logic          w_legal;
  logic          w_accept;
  logic [31:0]   w_prev;
  logic [31:0]   w_old;
  logic [31:0]   w_rot;
  logic [31:0]   w_sub;
  logic [31:0]   w_f;
  logic [IW-1:0] w_last;
  logic [IW-1:0] w_rk_base;

  assign w_nk_req = nk_of(key_len);
  assign w_legal  = (key_len != KEYLEN_ILL) && (32'(w_nk_req) <= NK_MAX);
  assign w_accept = (r_state == ST_IDLE) && start && w_legal;
  assign w_last   = {r_nr, 2'b11};

  assign w_prev = r_w[r_i - IW'(1)];
  assign w_old  = r_w[r_i - IW'(r_nk)];
  assign w_rot  = (r_p == 4'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (
      .i_a   (w_rot[8*b +: 8]),
      .o_y_c (w_sub[8*b +: 8])
    );
  end

  // Round-constant word at the start of each Nk group, extra SubWord mid-group for AES-256
  always_comb begin
    w_f = w_prev;
    if (r_p == 4'd0)
      w_f = w_sub ^ {r_rcon, 24'h0};
    else if (r_p == 4'd4 && r_nk == 4'd8)
      w_f = w_sub;
  end

  // Word store: not reset, only meaningful while keys_valid is high
  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int j = 0; j < int'(NK_MAX); j++)
        if (j < int'(w_nk_req)) r_w[j] <= key[255 - 32*j -: 32];
    end else if (r_state == ST_EXPAND) begin
      r_w[r_i] <= w_old ^ w_f;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_nk         <= '0;
      r_nr         <= '0;
      r_i          <= '0;
      r_p          <= '0;
      r_rcon       <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_keys_valid <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start && w_legal) begin
            r_nk         <= w_nk_req;
            r_nr         <= nr_of(key_len);
            r_i          <= IW'(w_nk_req);
            r_p          <= '0;
            r_rcon       <= 8'h01;
            r_keys_valid <= 1'b0;
            r_busy       <= 1'b1;
            r_state      <= ST_EXPAND;
          end else if (start) begin
            r_err <= 1'b1;
          end
        end
        ST_EXPAND: begin
          r_i <= r_i + IW'(1);
          r_p <= (r_p == r_nk - 4'd1) ? 4'd0 : r_p + 4'd1;
          if (r_p == 4'd0) r_rcon <= xtime(r_rcon);
          if (r_i == w_last) begin
            r_done       <= 1'b1;
            r_keys_valid <= 1'b1;
            r_busy       <= 1'b0;
            r_state      <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_rk_base = {rk_idx, 2'b00};

  // Indices beyond the latched Nr read as zero, which also keeps reads inside the store
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_rk_out <= '0;
    else if (rk_idx > r_nr)
      r_rk_out <= '0;
    else
      r_rk_out <= {r_w[w_rk_base], r_w[w_rk_base + IW'(1)],
                   r_w[w_rk_base + IW'(2)], r_w[w_rk_base + IW'(3)]};
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign keys_valid = r_keys_valid;
  assign err        = r_err;
  assign rk_out     = r_rk_out;

endmodule
